oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sprite-DMA sequencer for the 2A03 bus.
- Decodes CPU writes to the trigger register window, latches the source page and requests a CPU halt.
- Once the halt is granted, it owns the bus and copies 256 bytes from page XX00-XXFF to the PPU OAM data port, using alternating read/write cycles.
- Sits beside the CPU core on the shared address/data bus; the bus mux selects it while O_bus_own=1.

Parameters:
- P_addr_width, 16, bus address width
- P_data_width, 8, bus data width
- P_trig_lo, 16'h4014, trigger window lower bound (inclusive)
- P_trig_hi, 16'h4015, trigger window upper bound (exclusive)
- P_dest_addr, 16'h2004, fixed destination address for every write cycle

Ports:
- I_clock  in  1  system clock
- I_reset_n  in  1  asynchronous active-low reset
- I_cpu_addr  in  P_addr_width  CPU address, snooped for trigger decode
- I_cpu_data  in  P_data_width  CPU write data; the trigger write carries the source page
- I_cpu_write  in  1  CPU write strobe for the current cycle
- I_halt_ack  in  1  CPU has stopped and released the bus
- I_dma_rdata  in  P_data_width  bus read data during DMA read cycles
- O_halt  out  1  halt request to the CPU
- O_bus_own  out  1  DMA drives the bus this cycle
- O_addr  out  P_addr_width  DMA bus address
- O_data  out  P_data_width  DMA write data
- O_read  out  1  DMA read strobe
- O_write  out  1  DMA write strobe
- O_busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock domain. I_reset_n low asynchronously forces state IDLE, page=0, idx=0, latch=0, parity=0, and all outputs 0. Reset applied mid-transfer aborts the transfer with no further bus cycles; after reset releases, the block waits for a new trigger.
- Parity: a free-running bit toggles every clock, reset 0; even = 0.
- Trigger: I_cpu_write=1 with P_trig_lo <= I_cpu_addr < P_trig_hi, sampled at a rising edge in IDLE. On that edge, page <= I_cpu_data and the state goes to HALT. Triggers in any other state are ignored.
- HALT:
  - O_halt=1, O_busy=1, O_bus_own=0.
  - Stays in HALT while I_halt_ack=0.
  - When I_halt_ack=1, next state is ALIGN if parity is 1 on that edge, otherwise READ.
- ALIGN: one dummy cycle. O_halt=1, O_bus_own=1, O_read=O_write=0. Next state is READ.
- READ: O_bus_own=1, O_read=1, O_addr={page, idx}. latch <= I_dma_rdata at the end of the cycle. Next state is WRITE.
- WRITE:
  - O_bus_own=1, O_write=1, O_addr=P_dest_addr, O_data=latch.
  - idx <= idx+1 (8-bit, wraps).
  - If idx was 8'hFF, next state is IDLE; otherwise READ.
- IDLE: all outputs 0. O_halt drops in the first IDLE cycle.
- O_halt stays high from HALT through the final WRITE inclusive.
- Latency: after the ack edge, the transfer takes 512 bus cycles (513 with ALIGN).
- Output registration: all outputs are registered or decoded from registered state only. There is no combinational path from I_cpu_* to O_*.
- Page 8'hFF: source addresses FF00-FFFF are legal; there is no special handling.

Optional Feature:
- Macro: Q2A03_DMA_ABORT_EN.
- With the macro defined:
  - Extra input I_abort (1 bit).
  - I_abort=1 in HALT or ALIGN returns the block to IDLE next cycle.
  - I_abort=1 in READ completes the following WRITE, then goes to IDLE.
  - I_abort=1 in WRITE makes that WRITE the last cycle.
  - idx resets to 0 on abort.
- Without the macro: the port does not exist and a transfer always runs all 256 bytes.

Decomposition:
- Package q2a03_dma_pkg holds:
  - the state enum (IDLE, HALT, ALIGN, READ, WRITE)
  - default constants for the trigger window and destination address
  - the transfer length constant (256)
- Trigger decode instantiates the existing compare range checker as one sub-module, with I_value=I_cpu_addr, I_lower=P_trig_lo, I_upper=P_trig_hi; its O_inside is ANDed with I_cpu_write.
- No other sub-modules.

Test Plan:
- Basic copy:
  - Stimulus: write 8'h02 to 16'h4014 on an even-parity edge; ack one cycle later; source memory preloaded with byte = address low.
  - Required: 256 writes to 16'h2004 carrying 00..FF in order; reads addressed 16'h0200..16'h02FF; 512 bus cycles with no ALIGN.
- Odd alignment:
  - Stimulus: ack arrives on an odd-parity edge.
  - Required: exactly one ALIGN cycle with O_read=O_write=0; 513 owned cycles.
- Decode edges:
  - Stimulus: writes to 16'h4013 and 16'h4015; a read of 16'h4014.
  - Required: O_busy stays 0 for all three.
- Retrigger:
  - Stimulus: second write to 16'h4014 during the transfer.
  - Required: ignored; page unchanged; exactly 256 writes.
- Delayed ack and reset:
  - Stimulus: hold I_halt_ack=0 for 10 cycles, then 1.
  - Required: O_halt=1 throughout, O_bus_own=0 until the ack edge.
  - Stimulus: assert I_reset_n low at byte 100.
  - Required: all outputs 0 immediately, no further writes.
- Abort (Q2A03_DMA_ABORT_EN):
  - Stimulus: I_abort during READ of byte 5.
  - Required: the WRITE of byte 5 completes, then IDLE; 6 writes total.

Source files
------------

// File: rtl/q2a03_dma_pkg.sv
// Shared types and constants for the 2A03 sprite-DMA sequencer.
// Defaults cover the trigger window, the OAM data port and the fixed 256-byte transfer length.
package q2a03_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_t;

  localparam logic [15:0] TRIG_LO_DFLT   = 16'h4014;
  localparam logic [15:0] TRIG_HI_DFLT   = 16'h4015;
  localparam logic [15:0] DEST_ADDR_DFLT = 16'h2004;
  localparam int unsigned XFER_LEN       = 256;

endpackage

// File: rtl/oam_dma_ctrl_range.sv
// Half-open range compare: O_inside is high when I_lower <= I_value < I_upper (unsigned).
module oam_dma_ctrl_range #(
  parameter int P_width = 16
) (
  input  logic [P_width-1:0] I_value,
  input  logic [P_width-1:0] I_lower,
  input  logic [P_width-1:0] I_upper,
  output logic               O_inside
);

  assign O_inside = (I_value >= I_lower) && (I_value < I_upper);

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer: halts the CPU, then copies page XX00-XXFF to the OAM data port.
// Optional early termination through I_abort when Q2A03_DMA_ABORT_EN is defined.
module oam_dma_ctrl
  import q2a03_dma_pkg::*;
#(
  parameter int                      P_addr_width = 16,
  parameter int                      P_data_width = 8,
  parameter logic [P_addr_width-1:0] P_trig_lo    = TRIG_LO_DFLT,
  parameter logic [P_addr_width-1:0] P_trig_hi    = TRIG_HI_DFLT,
  parameter logic [P_addr_width-1:0] P_dest_addr  = DEST_ADDR_DFLT
) (
  input  logic                    I_clock,
  input  logic                    I_reset_n,
  input  logic [P_addr_width-1:0] I_cpu_addr,
  input  logic [P_data_width-1:0] I_cpu_data,
  input  logic                    I_cpu_write,
  input  logic                    I_halt_ack,
  input  logic [P_data_width-1:0] I_dma_rdata,
`ifdef Q2A03_DMA_ABORT_EN
  input  logic                    I_abort,
`endif
  output logic                    O_halt,
  output logic                    O_bus_own,
  output logic [P_addr_width-1:0] O_addr,
  output logic [P_data_width-1:0] O_data,
  output logic                    O_read,
  output logic                    O_write,
  output logic                    O_busy
);

  localparam int              IDX_W    = $clog2(XFER_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

  dma_state_t              state_q, state_d;
  logic [P_data_width-1:0] page_q;
  logic [IDX_W-1:0]        idx_q;
  logic [P_data_width-1:0] latch_q;
  logic                    parity_q;
  logic                    trig_inside;
  logic                    trig_hit;
  logic                    abort_now;
  logic                    abort_pend_q;

  oam_dma_ctrl_range #(
    .P_width (P_addr_width)
  ) u_trig_range (
    .I_value  (I_cpu_addr),
    .I_lower  (P_trig_lo),
    .I_upper  (P_trig_hi),
    .O_inside (trig_inside)
  );

  assign trig_hit = trig_inside & I_cpu_write;

`ifdef Q2A03_DMA_ABORT_EN
  assign abort_now = I_abort;

  // An abort seen during READ lets the paired WRITE finish before stopping.
  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      abort_pend_q <= 1'b0;
    end else begin
      abort_pend_q <= (state_q == ST_READ) && I_abort;
    end
  end
`else
  assign abort_now    = 1'b0;
  assign abort_pend_q = 1'b0;
`endif

  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    O_halt    = 1'b0;
    O_bus_own = 1'b0;
    O_addr    = '0;
    O_data    = '0;
    O_read    = 1'b0;
    O_write   = 1'b0;
    O_busy    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trig_hit) state_d = ST_HALT;
      end
      ST_HALT: begin
        O_halt = 1'b1;
        O_busy = 1'b1;
        if (abort_now)       state_d = ST_IDLE;
        else if (I_halt_ack) state_d = parity_q ? ST_ALIGN : ST_READ;
      end
      ST_ALIGN: begin
        O_halt    = 1'b1;
        O_bus_own = 1'b1;
        O_busy    = 1'b1;
        state_d   = abort_now ? ST_IDLE : ST_READ;
      end
      ST_READ: begin
        O_halt    = 1'b1;
        O_bus_own = 1'b1;
        O_busy    = 1'b1;
        O_read    = 1'b1;
        O_addr    = P_addr_width'({page_q, idx_q});
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        O_halt    = 1'b1;
        O_bus_own = 1'b1;
        O_busy    = 1'b1;
        O_write   = 1'b1;
        O_addr    = P_dest_addr;
        O_data    = latch_q;
        if ((idx_q == IDX_LAST) || abort_now || abort_pend_q) state_d = ST_IDLE;
        else                                                   state_d = ST_READ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Parity runs freely; the byte index only advances after each completed write.
  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      page_q   <= '0;
      idx_q    <= '0;
      latch_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      if ((state_q == ST_IDLE) && trig_hit) page_q <= I_cpu_data;
      if (state_q == ST_READ) latch_q <= I_dma_rdata;
      if (state_q == ST_WRITE) begin
        if (abort_now || abort_pend_q) idx_q <= '0;
        else                           idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: decode table, directed transfers, reset abort and randomized copies.
// Covers the I_abort port when built with Q2A03_DMA_ABORT_EN.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        cpu_write = 1'b0;
  logic        halt_ack = 1'b0;
  logic [7:0]  dma_rdata;
  logic        halt, bus_own, rd, wr, busy;
  logic [15:0] addr;
  logic [7:0]  data;
`ifdef Q2A03_DMA_ABORT_EN
  logic        abort = 1'b0;
`endif

  always #5 clk = ~clk;

  oam_dma_ctrl dut (
    .I_clock     (clk),
    .I_reset_n   (rst_n),
    .I_cpu_addr  (cpu_addr),
    .I_cpu_data  (cpu_data),
    .I_cpu_write (cpu_write),
    .I_halt_ack  (halt_ack),
    .I_dma_rdata (dma_rdata),
`ifdef Q2A03_DMA_ABORT_EN
    .I_abort     (abort),
`endif
    .O_halt      (halt),
    .O_bus_own   (bus_own),
    .O_addr      (addr),
    .O_data      (data),
    .O_read      (rd),
    .O_write     (wr),
    .O_busy      (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Source memory contents are a keyed function of the address.
  logic [7:0] key = 8'h00;
  function automatic logic [7:0] src_byte(input logic [15:0] a, input logic [7:0] k);
    return a[7:0] ^ k;
  endfunction
  assign dma_rdata = rd ? src_byte(addr, key) : 8'h00;

  // Edge count since reset release gives the expected parity of the next edge.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [15:0] rd_q[$];
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int owned = 0, aligns = 0, own_nohalt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_own) owned++;
      if (bus_own && !rd && !wr) aligns++;
      if (busy && !halt) own_nohalt++;
      if (rd) rd_q.push_back(addr);
      if (wr) begin
        wr_addr_q.push_back(addr);
        wr_data_q.push_back(data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs_all();
    return 32'({halt, bus_own, rd, wr, busy, addr, data});
  endfunction

  task automatic trigger(input logic [7:0] page, input int trig_par);
    int g = 0;
    while (((cyc % 2) != trig_par) && g < 4) begin
      tick();
      g++;
    end
    cpu_addr  = 16'h4014;
    cpu_data  = page;
    cpu_write = 1'b1;
    tick();
    cpu_write = 1'b0;
    cpu_addr  = 16'h0000;
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] page, input logic [7:0] k,
                          input int trig_par, input int ack_delay, input bit retrig);
    int rb, wb, ob, ab, hb, exp_align, guard, bad, n;
    key = k;
    trigger(page, trig_par);
    check({tag, "_halt_state"}, 32'({busy, halt, bus_own}), 32'b110);
    bad = 0;
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      if ({halt, bus_own} !== 2'b10) bad++;
    end
    check({tag, "_halt_hold"}, 32'(bad), 32'd0);
    halt_ack  = 1'b1;
    exp_align = cyc % 2;
    rb = rd_q.size(); wb = wr_addr_q.size();
    ob = owned; ab = aligns; hb = own_nohalt;
    tick();
    halt_ack = 1'b0;
    guard = 0;
    while (busy && guard < 2000) begin
      if (retrig && guard == 40) begin
        cpu_addr  = 16'h4014;
        cpu_data  = ~page;
        cpu_write = 1'b1;
      end else begin
        cpu_write = 1'b0;
      end
      tick();
      guard++;
    end
    cpu_write = 1'b0;
    check({tag, "_done"}, 32'(guard < 2000), 32'd1);
    check({tag, "_owned"}, 32'(owned - ob), 32'(512 + exp_align));
    check({tag, "_align"}, 32'(aligns - ab), 32'(exp_align));
    check({tag, "_halt_cover"}, 32'(own_nohalt - hb), 32'd0);
    check({tag, "_nwrites"}, 32'(wr_addr_q.size() - wb), 32'd256);
    check({tag, "_nreads"}, 32'(rd_q.size() - rb), 32'd256);
    n = wr_addr_q.size() - wb;
    if (n > 256) n = 256;
    if (rd_q.size() - rb < n) n = rd_q.size() - rb;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (wr_addr_q[wb+i] !== 16'h2004) bad++;
      if (wr_data_q[wb+i] !== src_byte({page, 8'(i)}, k)) bad++;
      if (rd_q[rb+i] !== {page, 8'(i)}) bad++;
    end
    check({tag, "_stream"}, 32'(bad), 32'd0);
    check({tag, "_idle_after"}, outs_all(), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic        exp_busy;
  } dec_vec_t;

  initial begin
    dec_vec_t vecs[5];
    int wb, g, wcnt;

    #200_000_0;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    dec_vec_t vecs[5];
    int wb, g, wcnt;

    vecs[0] = '{16'h4013, 8'h02, 1'b1, 1'b0};
    vecs[1] = '{16'h4015, 8'h02, 1'b1, 1'b0};
    vecs[2] = '{16'h4014, 8'h02, 1'b0, 1'b0};
    vecs[3] = '{16'h0014, 8'h02, 1'b1, 1'b0};
    vecs[4] = '{16'hC014, 8'h02, 1'b1, 1'b0};

    tick();
    tick();
    check("reset_outputs", outs_all(), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_after_release", outs_all(), 32'd0);

    for (int i = 0; i < 5; i++) begin
      cpu_addr  = vecs[i].a;
      cpu_data  = vecs[i].d;
      cpu_write = vecs[i].w;
      tick();
      cpu_write = 1'b0;
      tick();
      check($sformatf("decode_%0h_w%0d", vecs[i].a, vecs[i].w), 32'(busy), 32'(vecs[i].exp_busy));
    end

    run_xfer("basic",   8'h02, 8'h00, 0, 1, 1'b0);
    run_xfer("odd",     8'h03, 8'h00, 0, 0, 1'b0);
    run_xfer("retrig",  8'h80, 8'h5A, 1, 3, 1'b1);
    run_xfer("delayed", 8'hFF, 8'h00, 1, 10, 1'b0);

    // Reset partway through the copy must stop all bus activity at once.
    key = 8'h00;
    trigger(8'h33, 0);
    halt_ack = 1'b1;
    tick();
    halt_ack = 1'b0;
    wb = wr_addr_q.size();
    g = 0;
    while ((wr_addr_q.size() - wb) < 100 && g < 1000) begin
      tick();
      g++;
    end
    check("rst_reach_byte100", 32'(g < 1000), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_outputs_now", outs_all(), 32'd0);
    wcnt = wr_addr_q.size();
    tick();
    tick();
    check("rst_outputs_held", outs_all(), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("rst_no_more_writes", 32'(wr_addr_q.size()), 32'(wcnt));
    check("rst_idle", outs_all(), 32'd0);

`ifdef Q2A03_DMA_ABORT_EN
    key = 8'h00;
    trigger(8'h44, 0);
    halt_ack = 1'b1;
    tick();
    halt_ack = 1'b0;
    wb = wr_addr_q.size();
    g = 0;
    while (!(rd && addr == 16'h4405) && g < 100) begin
      tick();
      g++;
    end
    check("abort_reach_read5", 32'(g < 100), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    g = 0;
    while (busy && g < 100) begin
      tick();
      g++;
    end
    check("abort_stopped", 32'(busy), 32'd0);
    check("abort_nwrites", 32'(wr_addr_q.size() - wb), 32'd6);
    check("abort_last_data", 32'(wr_data_q[wr_data_q.size()-1]), 32'h05);
    trigger(8'h45, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_halt", outs_all(), 32'd0);
    run_xfer("post_abort", 8'h10, 8'h3C, 0, 2, 1'b0);
`endif

    for (int r = 0; r < 6; r++) begin
      run_xfer($sformatf("rand%0d", r), 8'($urandom), 8'($urandom),
               int'($urandom % 2), int'($urandom_range(0, 6)), 1'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
